// File: rtl/b7_enc_pkg.sv
// Shared types and sizes for the b7 streaming 16-to-4 bit encoder.
// The popcount helper is only used when B7_ENC_COUNT_EN is defined.
package b7_enc_pkg;

    localparam int VEC_W = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    function automatic logic [CNT_W-1:0] popcount(input logic [VEC_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < VEC_W; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/b7_pri_enc16.sv
// Combinational 16-to-4 priority encoder.
// The msb_first input picks whether the highest or the lowest set bit wins.
module b7_pri_enc16
    import b7_enc_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    input  logic             msb_first,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // NOTE: every output gets a default before the loops so no path leaves it unassigned (no latch).
    always_comb begin
        idx = '0;
        any = |vec;
        if (msb_first) begin
            for (int i = 0; i < VEC_W; i++) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = VEC_W - 1; i >= 0; i--) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/b7_4bit_enc_stream.sv
// Streams out the index of every set bit of an accepted 16-bit vector, one beat per handshake.
// Optional feature: define B7_ENC_COUNT_EN to add the registered bit_count output.
module b7_4bit_enc_stream
    import b7_enc_pkg::*;
#(
    parameter bit SCAN_MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req_vec,
    input  logic        req_valid,
    output logic        req_ready,
    output logic [3:0]  idx_out,
    output logic        idx_valid,
    input  logic        idx_ready,
    output logic        idx_last,
    output logic        zero_err
`ifdef B7_ENC_COUNT_EN
    ,
    output logic [4:0]  bit_count
`endif
);

    state_e           state_q;
    logic [VEC_W-1:0] pending_q;
    logic             zero_err_q;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             single_bit;
    logic             accept;
    logic             beat_done;

    b7_pri_enc16 u_pri_enc (
        .vec       (pending_q),
        .msb_first (SCAN_MSB_FIRST),
        .idx       (enc_idx),
        .any       (enc_any)
    );

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
    assign single_bit = enc_any && ((pending_q & (pending_q - VEC_W'(1))) == '0);

    assign req_ready = (state_q == IDLE);
    assign idx_valid = (state_q == EMIT);
    assign idx_out   = idx_valid ? enc_idx : '0;
    assign idx_last  = idx_valid && single_bit;
    assign zero_err  = zero_err_q;

    assign accept    = req_valid && req_ready;
    assign beat_done = idx_valid && idx_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            zero_err_q <= 1'b0;
        end else begin
            zero_err_q <= accept && (req_vec == '0);
            case (state_q)
                IDLE: begin
                    if (accept && (req_vec != '0)) begin
                        pending_q <= req_vec;
                        state_q   <= EMIT;
                    end
                end
                EMIT: begin
                    if (beat_done) begin
                        pending_q <= pending_q & ~(VEC_W'(1) << enc_idx);
                        if (single_bit) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef B7_ENC_COUNT_EN
    logic [CNT_W-1:0] bit_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_count_q <= '0;
        end else if (accept) begin
            bit_count_q <= popcount(req_vec);
        end
    end

    assign bit_count = bit_count_q;
`endif

endmodule

// File: tb/tb_b7_4bit_enc_stream.sv
// Self-checking bench for b7_4bit_enc_stream: one LSB-first and one MSB-first instance.
// Expected beats come from a scoreboard queue filled when each vector is driven.
module tb_b7_4bit_enc_stream;

    typedef struct packed {
        logic [3:0] idx;
        logic       last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic [15:0] req_vec;
    logic        req_valid;
    logic        idx_ready;

    logic       rr0, iv0, il0, ze0, rr1, iv1, il1, ze1;
    logic [3:0] io0, io1;
`ifdef B7_ENC_COUNT_EN
    logic [4:0] bc0, bc1, m_cnt;
`endif

    logic       m_ready, m_valid, m_last, m_zero;
    logic [3:0] m_idx;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    b7_4bit_enc_stream #(.SCAN_MSB_FIRST(1'b0)) u_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_vec   (req_vec),
        .req_valid (req_valid && !sel),
        .req_ready (rr0),
        .idx_out   (io0),
        .idx_valid (iv0),
        .idx_ready (idx_ready),
        .idx_last  (il0),
        .zero_err  (ze0)
`ifdef B7_ENC_COUNT_EN
        ,
        .bit_count (bc0)
`endif
    );

    b7_4bit_enc_stream #(.SCAN_MSB_FIRST(1'b1)) u_msb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_vec   (req_vec),
        .req_valid (req_valid && sel),
        .req_ready (rr1),
        .idx_out   (io1),
        .idx_valid (iv1),
        .idx_ready (idx_ready),
        .idx_last  (il1),
        .zero_err  (ze1)
`ifdef B7_ENC_COUNT_EN
        ,
        .bit_count (bc1)
`endif
    );

    assign m_ready = sel ? rr1 : rr0;
    assign m_valid = sel ? iv1 : iv0;
    assign m_last  = sel ? il1 : il0;
    assign m_zero  = sel ? ze1 : ze0;
    assign m_idx   = sel ? io1 : io0;
`ifdef B7_ENC_COUNT_EN
    assign m_cnt   = sel ? bc1 : bc0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference beats: walk the bits in scan order, last flag on the final set bit.
    task automatic push_model(input logic [15:0] v, input bit msb);
        int n;
        int k;
        int b;
        n = $countones(v);
        k = 0;
        for (int j = 0; j < 16; j++) begin
            b = msb ? 15 - j : j;
            if (v[b]) begin
                k++;
                exp_q.push_back('{idx: 4'(b), last: (k == n)});
            end
        end
    endtask

    task automatic send(input logic [15:0] v, input bit msb);
        check("req_ready_before_send", 32'(m_ready), 32'd1);
        req_vec   = v;
        req_valid = 1'b1;
        push_model(v, msb);
        tick();
        req_valid = 1'b0;
        req_vec   = 16'($urandom);
    endtask

    task automatic drain(input bit stall, output int ticks);
        int    budget;
        bit    held;
        bit    r;
        beat_t saved;
        beat_t e;
        budget = 0;
        held   = 1'b0;
        saved  = '0;
        ticks  = 0;
        while (budget < 100) begin
            if (held) begin
                check("stall_hold_valid", 32'(m_valid), 32'd1);
                check("stall_hold_idx", 32'(m_idx), 32'(saved.idx));
                check("stall_hold_last", 32'(m_last), 32'(saved.last));
                held = 1'b0;
            end
            if (!m_valid && exp_q.size() == 0) break;
            r = stall ? ticks[0] : 1'b1;
            idx_ready = r;
            if (m_valid) begin
                check("emit_req_ready_low", 32'(m_ready), 32'd0);
                if (r) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 32'(m_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_idx", 32'(m_idx), 32'(e.idx));
                        check("beat_last", 32'(m_last), 32'(e.last));
                    end
                end else begin
                    saved.idx  = m_idx;
                    saved.last = m_last;
                    held       = 1'b1;
                end
            end
            tick();
            ticks++;
            budget++;
        end
        idx_ready = 1'b1;
        check("drain_within_budget", 32'(budget < 100), 32'd1);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int    t;
        beat_t e;

        rst_n     = 1'b0;
        sel       = 1'b0;
        req_vec   = '0;
        req_valid = 1'b0;
        idx_ready = 1'b0;

        // Reset state
        #12;
        check("rst_req_ready", 32'(m_ready), 32'd1);
        check("rst_idx_valid", 32'(m_valid), 32'd0);
        check("rst_idx_out", 32'(m_idx), 32'd0);
        check("rst_idx_last", 32'(m_last), 32'd0);
        check("rst_zero_err", 32'(m_zero), 32'd0);
`ifdef B7_ENC_COUNT_EN
        check("rst_bit_count", 32'(m_cnt), 32'd0);
`endif
        #10 rst_n = 1'b1;
        tick();

        // Single bit: one beat, req_ready back two cycles after accept
        idx_ready = 1'b1;
        send(16'h0001, 1'b0);
        check("t0001_latency_valid", 32'(m_valid), 32'd1);
        drain(1'b0, t);
        check("t0001_beat_cycles", 32'(t), 32'd1);
        check("t0001_ready_after", 32'(m_ready), 32'd1);

        // Multi-bit LSB first
        send(16'h8421, 1'b0);
        check("t8421_latency_valid", 32'(m_valid), 32'd1);
`ifdef B7_ENC_COUNT_EN
        check("t8421_bit_count", 32'(m_cnt), 32'd4);
`endif
        drain(1'b0, t);
        check("t8421_beat_cycles", 32'(t), 32'd4);

        // Multi-bit MSB first with stalls
        sel = 1'b1;
        tick();
        send(16'h8421, 1'b1);
        check("t8421m_latency_valid", 32'(m_valid), 32'd1);
`ifdef B7_ENC_COUNT_EN
        check("t8421m_bit_count", 32'(m_cnt), 32'd4);
`endif
        drain(1'b1, t);
        check("t8421m_beat_cycles", 32'(t), 32'd8);

        // All-zero vector
        sel = 1'b0;
        tick();
        send(16'h0000, 1'b0);
        check("zero_err_pulse", 32'(m_zero), 32'd1);
        check("zero_no_valid", 32'(m_valid), 32'd0);
        check("zero_ready_stays", 32'(m_ready), 32'd1);
`ifdef B7_ENC_COUNT_EN
        check("zero_bit_count", 32'(m_cnt), 32'd0);
`endif
        tick();
        check("zero_err_cleared", 32'(m_zero), 32'd0);
        check("zero_still_no_valid", 32'(m_valid), 32'd0);

        // Full vector: 16 back-to-back beats
        send(16'hFFFF, 1'b0);
`ifdef B7_ENC_COUNT_EN
        check("tffff_bit_count", 32'(m_cnt), 32'd16);
`endif
        drain(1'b0, t);
        check("tffff_beat_cycles", 32'(t), 32'd16);

        // Reset in the middle of a full vector
        send(16'hFFFF, 1'b0);
        idx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            check("rstmid_beat_idx", 32'(m_idx), 32'(e.idx));
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_idx_valid", 32'(m_valid), 32'd0);
        check("rstmid_idx_out", 32'(m_idx), 32'd0);
        check("rstmid_idx_last", 32'(m_last), 32'd0);
        check("rstmid_req_ready", 32'(m_ready), 32'd1);
`ifdef B7_ENC_COUNT_EN
        check("rstmid_bit_count", 32'(m_cnt), 32'd0);
`endif
        exp_q.delete();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_no_beat", 32'(m_valid), 32'd0);
        end

        // New accept after reset works normally
        send(16'h0003, 1'b0);
        drain(1'b0, t);
        check("post_rst_beat_cycles", 32'(t), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/b7_4bit_enc_stream.md
B7_4BIT_ENC_STREAM -- requirements
Module: b7_4bit_enc_stream

Interface
REQ-001 Parameter SCAN_MSB_FIRST, default 0, selects scan order: 0 = lowest set bit first; 1 = highest set bit first.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_vec  input  16  one-hot/multi-hot request vector to encode.
REQ-005 req_valid  input  1  req_vec valid.
REQ-006 req_ready  output  1  block can accept a vector.
REQ-007 idx_out  output  4  binary index of current set bit.
REQ-008 idx_valid  output  1  idx_out valid.
REQ-009 idx_ready  input  1  downstream accepts idx_out.
REQ-010 idx_last  output  1  current beat is the final set bit of the vector.
REQ-011 zero_err  output  1  one-cycle pulse: all-zero vector was accepted.
REQ-012 bit_count  output  5  population count of last accepted vector (present only under B7_ENC_COUNT_EN).

Function
REQ-013 FSM states: IDLE, EMIT.
REQ-014 IDLE: req_ready=1, idx_valid=0.
REQ-015 Accept = req_valid && req_ready; on accept with nonzero req_vec, the block shall load the pending register with req_vec and enter EMIT.
REQ-016 On accept with req_vec==0, the block shall stay in IDLE, emit no beat, and assert zero_err for exactly the next cycle.
REQ-017 Latency: vector accepted at edge N gives idx_valid=1 after edge N (first beat visible in cycle N+1).
REQ-018 EMIT: req_ready=0, idx_valid=1, idx_out = lowest set bit (highest if SCAN_MSB_FIRST=1) of the pending register.
REQ-019 idx_last=1 when the pending register has exactly one bit set, and 0 otherwise.
REQ-020 idx_out, idx_valid, and idx_last shall hold stable while idx_valid && !idx_ready.
REQ-021 On idx_valid && idx_ready, the block shall clear the reported bit in the pending register; if idx_last, the block shall go to IDLE.
REQ-022 No same-cycle reload: req_ready rises the cycle after the last beat, giving one idle bubble between vectors.
REQ-023 Vector 16'hFFFF with idx_ready held high shall produce 16 consecutive beats, 0..15 (or 15..0).
REQ-024 req_vec changes while req_ready=0 shall be ignored.

Reset
REQ-025 rst_n low shall immediately force IDLE, pending=0, idx_valid=0, idx_last=0, idx_out=0, zero_err=0, bit_count=0; req_ready=1 once in IDLE.
REQ-026 Reset during EMIT shall discard remaining bits; no beat is emitted after reset release until a new accept.

Configuration
REQ-027 With B7_ENC_COUNT_EN defined, the bit_count port shall exist and register the popcount (0..16) of each accepted vector, including 0 for the zero case, holding until the next accept.
REQ-028 Without B7_ENC_COUNT_EN, the bit_count port and its logic shall be absent; all other behaviour is identical.

Structure
REQ-029 Package b7_enc_pkg shall hold the state enum (IDLE, EMIT), VEC_W=16, IDX_W=4, and CNT_W=5.
REQ-030 Sub-module b7_pri_enc16 shall be a combinational 16-to-4 priority encoder with direction input and any-bit flag, instantiated on the pending register.

Verification
REQ-031 Reset, then req_vec=16'h0001 accepted, idx_ready=1 -> one beat idx_out=0, idx_last=1; req_ready=1 two cycles after accept.
REQ-032 req_vec=16'h8421, SCAN_MSB_FIRST=0, idx_ready=1 -> beats 0,5,10,15; idx_last only on 15; bit_count=4 (with macro).
REQ-033 Same vector with SCAN_MSB_FIRST=1 and idx_ready toggling 1/0 -> beats 15,10,5,0; outputs stable during stalls.
REQ-034 req_vec=16'h0000 accepted -> no idx_valid, zero_err single-cycle pulse, req_ready stays 1.
REQ-035 req_vec=16'hFFFF, rst_n dropped after 3rd beat -> outputs zero immediately; after release, no beats until the next accept.
